// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared state encoding and conv-output geometry for the UART load/dump blocks
package tl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } tl_state_t;

    // Default conv-output buffer geometry: {c, x, y} with y fastest.
    localparam int TL_C_DIM  = 8;
    localparam int TL_X_DIM  = 12;
    localparam int TL_Y_DIM  = 12;
    localparam int TL_C_BITS = 3;
    localparam int TL_X_BITS = 4;
    localparam int TL_Y_BITS = 4;

    // Width of a counter that must hold values 0..t-1; never narrower than 1 bit.
    function automatic int tl_cnt_bits(input int t);
        return (t > 2) ? $clog2(t) : 1;
    endfunction

endpackage

// File: rtl/addr_walker.sv
// rtl/addr_walker.sv - nested y/x/c address counter producing the {c, x, y} RAM address
//   clk   : clock
//   rst   : synchronous active-high reset
//   clear : return to address 0
//   step  : advance one location (y fastest, then x, then c); holds at the last location
//   addr  : {c, x, y}, y in the LSBs
//   last  : current location is (C_DIM-1, X_DIM-1, Y_DIM-1)
module addr_walker
    import tl_pkg::*;
#(
    parameter int C_DIM  = TL_C_DIM,
    parameter int X_DIM  = TL_X_DIM,
    parameter int Y_DIM  = TL_Y_DIM,
    parameter int C_BITS = TL_C_BITS,
    parameter int X_BITS = TL_X_BITS,
    parameter int Y_BITS = TL_Y_BITS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            step,
    output logic [C_BITS+X_BITS+Y_BITS-1:0] addr,
    output logic                            last
);

    localparam logic [C_BITS-1:0] C_MAX = C_BITS'(C_DIM - 1);
    localparam logic [X_BITS-1:0] X_MAX = X_BITS'(X_DIM - 1);
    localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(Y_DIM - 1);

    logic [C_BITS-1:0] c_q;
    logic [X_BITS-1:0] x_q;
    logic [Y_BITS-1:0] y_q;

    assign last = (c_q == C_MAX) && (x_q == X_MAX) && (y_q == Y_MAX);
    assign addr = {c_q, x_q, y_q};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            c_q <= '0;
            x_q <= '0;
            y_q <= '0;
        end else if (step && !last) begin
            if (y_q == Y_MAX) begin
                y_q <= '0;
                if (x_q == X_MAX) begin
                    x_q <= '0;
                    c_q <= c_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end else begin
                y_q <= y_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// rtl/uart_word_loader.sv - assembles UART bytes LSB-first into 32-bit words and writes them to RAM
//   clk       : clock
//   rst       : synchronous active-high reset
//   start     : one-cycle pulse, begin (or restart) a load at address 0
//   rx_irdy   : one-cycle strobe, rx_data valid
//   rx_data   : received byte
//   mem_we    : one-cycle write pulse per assembled word
//   mem_addr  : {c, x, y} write address, valid with mem_we
//   mem_wdata : assembled word, valid with mem_we
//   busy      : high while receiving
//   done      : high from the final write until the next start or rst
//   err       : one-cycle pulse when a partial word is dropped by timeout
module uart_word_loader
    import tl_pkg::*;
#(
    parameter int C_DIM   = TL_C_DIM,
    parameter int X_DIM   = TL_X_DIM,
    parameter int Y_DIM   = TL_Y_DIM,
    parameter int C_BITS  = TL_C_BITS,
    parameter int X_BITS  = TL_X_BITS,
    parameter int Y_BITS  = TL_Y_BITS,
    parameter int TIMEOUT = 1000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            rx_irdy,
    input  logic [7:0]                      rx_data,
    output logic                            mem_we,
    output logic [C_BITS+X_BITS+Y_BITS-1:0] mem_addr,
    output logic [31:0]                     mem_wdata,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int AW    = C_BITS + X_BITS + Y_BITS;
    localparam int CNT_W = tl_cnt_bits(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT - 1);

    tl_state_t        state_q;
    tl_state_t        state_d;
    logic [1:0]       byte_idx_q;
    logic [23:0]      asm_q;      // lanes 0..2; lane 3 goes straight into mem_wdata
    logic [CNT_W-1:0] tmo_cnt_q;

    logic             clear_load;
    logic             take_byte;
    logic             word_done;
    logic             tmo_fire;
    logic [AW-1:0]    walk_addr;
    logic             walk_last;

    addr_walker #(
        .C_DIM  (C_DIM),
        .X_DIM  (X_DIM),
        .Y_DIM  (Y_DIM),
        .C_BITS (C_BITS),
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_addr_walker (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_load),
        .step  (word_done),
        .addr  (walk_addr),
        .last  (walk_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start has priority over a same-cycle byte, which is simply dropped.
    always_comb begin
        state_d    = state_q;
        clear_load = 1'b0;
        take_byte  = 1'b0;
        word_done  = 1'b0;
        tmo_fire   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clear_load = 1'b1;
                    state_d    = ST_RECV;
                end
            end
            ST_RECV: begin
                if (start) begin
                    clear_load = 1'b1;
                end else if (rx_irdy) begin
                    take_byte = 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        word_done = 1'b1;
                        if (walk_last) begin
                            state_d = ST_DONE;
                        end
                    end
                end else if ((byte_idx_q != 2'd0) && (tmo_cnt_q == TMO_MAX)) begin
                    tmo_fire = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q <= '0;
            asm_q      <= '0;
            tmo_cnt_q  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            mem_we <= word_done;
            err    <= tmo_fire;
            busy   <= (state_d == ST_RECV);
            done   <= (state_d == ST_DONE);

            if (clear_load || tmo_fire) begin
                byte_idx_q <= '0;
                tmo_cnt_q  <= '0;
            end else if (take_byte) begin
                case (byte_idx_q)
                    2'd0:    asm_q[7:0]   <= rx_data;
                    2'd1:    asm_q[15:8]  <= rx_data;
                    2'd2:    asm_q[23:16] <= rx_data;
                    default: ;
                endcase
                byte_idx_q <= byte_idx_q + 2'd1;
                tmo_cnt_q  <= '0;
            end else if ((state_q == ST_RECV) && (byte_idx_q != 2'd0)) begin
                // tmo_fire resets the counter at TMO_MAX, so this never wraps.
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end

            if (word_done) begin
                mem_wdata <= {rx_data, asm_q};
                mem_addr  <= walk_addr;
            end
        end
    end

endmodule
